// File: rtl/demux_1t4_tdm.sv
// Receive side of the 4-channel TDM link: locks onto the slot-0 frame marker,
// regenerates the slot index, and delivers each complete frame as a registered word.
module demux_1t4_tdm #(
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       F,
  input  logic       Sync,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic [1:0] Sel,
  output logic       Frame_valid,
  output logic       Locked,
  output logic       Sync_err
);

  localparam int unsigned SLOT_W     = 2;
  localparam int unsigned MISS_W     = 3;
  localparam int unsigned MISS_CNT_W = MISS_W + 1;
  localparam int unsigned SHADOW_W   = 3;
  localparam int unsigned WORD_W     = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [SLOT_W-1:0]     slot, slot_nxt;
  logic [MISS_W-1:0]     miss, miss_nxt;
  logic [SHADOW_W-1:0]   shadow, shadow_nxt;
  logic [WORD_W-1:0]     word, word_nxt;
  logic                  fv, fv_nxt;
  logic                  err, err_nxt;
  logic [MISS_CNT_W-1:0] miss_inc;

  // State, slot tracking and frame registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state  <= HUNT;
      slot   <= '0;
      miss   <= '0;
      shadow <= '0;
      word   <= '0;
      fv     <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      slot   <= slot_nxt;
      miss   <= miss_nxt;
      shadow <= shadow_nxt;
      word   <= word_nxt;
      fv     <= fv_nxt;
      err    <= err_nxt;
    end
  end

  // Next-state, capture and frame-assembly logic
  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    miss_nxt   = miss;
    shadow_nxt = shadow;
    word_nxt   = word;
    fv_nxt     = 1'b0;
    err_nxt    = 1'b0;
    miss_inc   = {1'b0, miss} + MISS_CNT_W'(1);

    unique case (state)
      HUNT: begin
        if (Sync) begin
          shadow_nxt[0] = F;
          slot_nxt      = SLOT_W'(1);
          miss_nxt      = '0;
          state_nxt     = LOCKED;
        end
      end
      LOCKED: begin
        if (slot == '0) begin
          if (Sync) begin
            miss_nxt      = '0;
            shadow_nxt[0] = F;
            slot_nxt      = SLOT_W'(1);
          end else begin
            err_nxt = 1'b1;
            // Flywheel through a lost marker until the miss budget is spent
            if (miss_inc < MISS_CNT_W'(MISS_LIMIT)) begin
              miss_nxt      = miss_inc[MISS_W-1:0];
              shadow_nxt[0] = F;
              slot_nxt      = SLOT_W'(1);
            end else begin
              state_nxt = HUNT;
              slot_nxt  = '0;
              miss_nxt  = '0;
            end
          end
        end else if (Sync) begin
          // Misplaced marker: abandon the frame and restart at this bit
          err_nxt       = 1'b1;
          shadow_nxt[0] = F;
          slot_nxt      = SLOT_W'(1);
        end else begin
          case (slot)
            SLOT_W'(1): shadow_nxt[1] = F;
            SLOT_W'(2): shadow_nxt[2] = F;
            default: begin
              word_nxt = {shadow[0], shadow[1], shadow[2], F};
              fv_nxt   = 1'b1;
            end
          endcase
          slot_nxt = slot + SLOT_W'(1);
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  assign A           = word[3];
  assign B           = word[2];
  assign C           = word[1];
  assign D           = word[0];
  assign Sel         = slot;
  assign Frame_valid = fv;
  assign Locked      = (state == LOCKED);
  assign Sync_err    = err;

endmodule
